fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset or start.
REQ-002 Parameter IMEM_AW, default 14: instruction-memory word-address width.
REQ-003 The module has one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins fetching at RESET_PC from IDLE.
REQ-007 halt  in  1  stops fetching and flushes; returns to IDLE.
REQ-008 redirect  in  1  load npc as the next fetch address (taken branch/jump/jr).
REQ-009 npc  in  32  next PC from the upstream pc_incrementer; sampled only when redirect=1.
REQ-010 imem_en  out  1  instruction-memory read enable.
REQ-011 imem_addr  out  IMEM_AW  word address, equal to fetch_pc[IMEM_AW+1:2].
REQ-012 imem_rdata  in  32  read data, valid exactly 1 cycle after imem_en=1.
REQ-013 if_valid  out  1  if_pc/if_inst hold a valid instruction.
REQ-014 if_ready  in  1  decode accepts; transfer occurs when if_valid & if_ready.
REQ-015 if_pc  out  32  byte address of if_inst.
REQ-016 if_inst  out  32  fetched instruction word.
REQ-017 fetch_err  out  1  sticky misaligned-redirect error flag.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and ERR: IDLE->RUN on start; RUN->IDLE on halt; RUN->ERR on redirect with npc[1:0]!=0; ERR is left only by rst.
REQ-019 In RUN, a request (imem_en=1, address fetch_pc) SHALL issue when occupancy + inflight - pop < 2, where pop = if_valid & if_ready; after each issue, fetch_pc advances by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 Each response SHALL be written into a 2-entry FIFO together with its request PC; occupancy never exceeds 2 and no response is ever dropped except by REQ-021/022.
REQ-021 On a redirect cycle in RUN with an aligned npc: the FIFO SHALL be cleared, if_valid SHALL be 0 from the next cycle until new data arrives, the response arriving in that cycle SHALL be discarded, a request SHALL issue at npc in the same cycle, and fetch_pc <= npc+4.
REQ-022 Redirect SHALL have priority over a simultaneous pop and a simultaneous response; halt SHALL have priority over redirect; start outside IDLE SHALL be ignored.
REQ-023 Minimum latency SHALL be 2 cycles: start at cycle t -> request at t+1 -> if_valid=1 with if_pc=RESET_PC at t+2.
REQ-024 With if_ready held at 1, one instruction SHALL be delivered per cycle with no bubbles.
REQ-025 if_valid/if_pc/if_inst SHALL hold stable while if_valid=1 and if_ready=0.
REQ-026 In IDLE and ERR: imem_en=0, if_valid=0, and the FIFO is empty; halt and entry to ERR discard the in-flight response.
REQ-027 fetch_err SHALL be set on entry to ERR and held until rst.

Reset
REQ-028 On rst: state=IDLE, fetch_pc=RESET_PC, FIFO empty, inflight=0, imem_en=0, if_valid=0, if_pc=0, if_inst=0, fetch_err=0.
REQ-029 rst asserted mid-operation SHALL override all other inputs, and the response arriving in the cycle after rst SHALL be discarded.

Structure
REQ-030 The state encoding (IDLE/RUN/ERR) and the NOP/reset-PC constants SHALL reside in the shared cpu_pkg package.
REQ-031 The 2-entry PC+instruction buffer SHALL be a sub-module fetch_fifo with push, pop, clear, and count ports.

Verification
REQ-032 Scenario: rst, then start, with if_ready=1 -> if_pc = 0, 4, 8, 12 on consecutive cycles from t+2, and if_inst = memory words 0..3.
REQ-033 Scenario: hold if_ready=0 for 5 cycles -> occupancy 2, imem_en=0 and outputs stable; release if_ready -> the sequence continues with no gap or duplicate.
REQ-034 Scenario: redirect with npc=32'h0000_0100 while the FIFO is full -> the next delivered if_pc=32'h100, no stale PC appears, and the following PC is 32'h104.
REQ-035 Scenario: redirect with npc=32'h0000_0102 -> fetch_err=1, state ERR, imem_en=0 forever; after rst, fetch_err=0.
REQ-036 Scenario: fetch_pc=32'hFFFF_FFFC -> the next if_pc after it is 32'h0000_0000.
REQ-037 Scenario: redirect and halt in the same cycle -> IDLE, if_valid=0 next cycle; a subsequent start resumes at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset/NOP constants, and the
// PC+instruction record carried through the fetch buffer.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction addresses must be word aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory read port plus the decode handshake.
// master = fetch unit, slave = memory/decode side.
interface fetch_unit_if #(
    parameter int IMEM_AW = 14
);
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               if_valid;
    logic               if_ready;
    logic [31:0]        if_pc;
    logic [31:0]        if_inst;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        output if_valid, if_pc, if_inst,
        input  if_ready
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        input  if_valid, if_pc, if_inst,
        output if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry PC+instruction buffer. clear and rst empty it; the caller
// guarantees push never overflows and pop never underflows.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // Pointer and occupancy update; clear wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage; entries come up holding a harmless NOP record.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries[0] <= '{pc: RESET_PC_DEFAULT, inst: NOP_INST};
            entries[1] <= '{pc: RESET_PC_DEFAULT, inst: NOP_INST};
        end else if (push) begin
            entries[wr_ptr] <= wdata;
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Issues sequential word reads, buffers up to two
// responses with their PCs, and hands them to decode over a valid/ready
// handshake. A response arriving while the buffer is empty is forwarded
// straight to decode so the start-to-valid latency is two cycles.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] npc,
    fetch_unit_if.master bus,
    output logic        fetch_err
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic         inflight;
    logic [31:0]  inflight_pc;

    fetch_entry_t head;
    logic [1:0]   count;

    logic         running;
    logic         redir_ok;
    logic         redir_bad;
    logic         flush;
    logic         pop;
    logic         room;
    logic [31:0]  req_pc;
    logic         fifo_push;
    logic         fifo_pop;

    assign running   = (state == RUN);
    assign redir_ok  = running && redirect && !halt && !pc_misaligned(npc);
    assign redir_bad = running && redirect && !halt &&  pc_misaligned(npc);
    // Halt or any redirect in RUN throws away buffered and arriving data.
    assign flush     = running && (halt || redirect);

    // Decode view: buffer head first, otherwise the response landing now.
    always_comb begin
        bus.if_valid = (count != 2'd0) || inflight;
        bus.if_pc    = 32'h0;
        bus.if_inst  = 32'h0;
        if (count != 2'd0) begin
            bus.if_pc   = head.pc;
            bus.if_inst = head.inst;
        end else if (inflight) begin
            bus.if_pc   = inflight_pc;
            bus.if_inst = bus.imem_rdata;
        end
    end

    assign pop = bus.if_valid && bus.if_ready;

    // Issue only if the result is guaranteed a buffer slot: occupancy plus
    // outstanding read, less what decode takes this cycle, stays under two.
    assign room = ({1'b0, count} + {2'b00, inflight}) < ({2'b00, pop} + 3'd2);

    assign req_pc        = redir_ok ? npc : fetch_pc;
    assign bus.imem_en   = !rst && (redir_ok || (running && !halt && !redirect && room));
    assign bus.imem_addr = req_pc[IMEM_AW+1:2];

    // A response consumed directly by decode never enters the buffer.
    assign fifo_push = inflight && !(count == 2'd0 && pop);
    assign fifo_pop  = pop && (count != 2'd0);

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush),
        .wdata ('{pc: inflight_pc, inst: bus.imem_rdata}),
        .head  (head),
        .count (count)
    );

    // Control FSM plus fetch PC, outstanding-read tracking and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            fetch_err   <= 1'b0;
        end else begin
            // imem_en is already low on halt, error entry and outside RUN,
            // so the next response is dropped in exactly those cases.
            inflight <= bus.imem_en;
            if (bus.imem_en) inflight_pc <= req_pc;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        fetch_pc <= RESET_PC;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state <= IDLE;
                    end else if (redir_bad) begin
                        state     <= ERR;
                        fetch_err <= 1'b1;
                    end else if (bus.imem_en) begin
                        fetch_pc <= req_pc + 32'd4;
                    end
                end
                ERR: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
